// File: rtl/texel_fetch.sv
// Texel fetch: one texture read per pixel plus a CLUT read for 4/8-bit formats, one outstanding read.
// Zero-wait latency 2*reads+1 cycles; no new pair is accepted until the result is taken on i_texReady.
module texel_fetch (
  input  logic        clk,
  input  logic        i_nrst,
  input  logic        i_req,
  output logic        o_reqReady,
  input  logic [18:0] i_texAdrL,
  input  logic [18:0] i_texAdrR,
  input  logic [1:0]  i_subUL,
  input  logic [1:0]  i_subUR,
  input  logic [1:0]  i_format,
  input  logic        i_enR,
  input  logic [5:0]  i_clutX,
  input  logic [8:0]  i_clutY,
  output logic        o_memReq,
  output logic [18:0] o_memAdr,
  input  logic        i_memAck,
  input  logic        i_memValid,
  input  logic [15:0] i_memData,
  output logic        o_texValid,
  input  logic        i_texReady,
  output logic [15:0] o_texL,
  output logic [15:0] o_texR
);

  typedef enum logic [2:0] {IDLE, RD_TEX, WT_TEX, RD_CLUT, WT_CLUT, OUT} state_t;

  state_t      state;
  state_t      nxt;
  state_t      fin_nxt;

  logic [18:0] adr_l;
  logic [18:0] adr_r;
  logic [1:0]  sub_l;
  logic [1:0]  sub_r;
  logic [1:0]  fmt;
  logic        en_r;
  logic [5:0]  clut_x;
  logic [8:0]  clut_y;
  logic        side;
  logic [15:0] tex_word;

  logic        use_clut;
  logic        shared;
  logic        pix_done;
  logic        go_r;
  logic [15:0] cur_word;
  logic [1:0]  cur_sub;
  logic [7:0]  cur_idx;
  logic [9:0]  clut_col;
  logic [18:0] clut_adr;

  logic        req_d;
  logic [18:0] adr_d;
  logic        ready_d;
  logic        valid_d;

  function automatic logic [7:0] tex_index(input logic [15:0] w, input logic [1:0] s,
                                           input logic [1:0] f);
    logic [15:0] sh;
    logic [7:0]  r;
    sh = w >> {s, 2'b00};
    if (f == 2'd0) r = {4'd0, sh[3:0]};
    else           r = s[0] ? w[15:8] : w[7:0];
    return r;
  endfunction

  assign use_clut = ~fmt[1];
  assign shared   = (adr_r == adr_l);
  assign pix_done = i_memValid && ((state == WT_TEX && !use_clut) || state == WT_CLUT);
  assign go_r     = pix_done && !side && en_r;

  // The half-word being decoded is live data on the texture response, else the latched copy
  // (the R pixel reusing the L half-word).
  assign cur_word = (state == WT_TEX) ? i_memData : tex_word;
  assign cur_sub  = (go_r || side) ? sub_r : sub_l;
  assign cur_idx  = tex_index(cur_word, cur_sub, fmt);
  assign clut_col = {clut_x, 4'b0000} + {2'b00, cur_idx};
  assign clut_adr = {clut_y, clut_col};

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    fin_nxt = OUT;
    if (!side && en_r) begin
      if (!shared)       fin_nxt = RD_TEX;
      else if (use_clut) fin_nxt = RD_CLUT;
      else               fin_nxt = OUT;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (i_req)      nxt = RD_TEX;
      RD_TEX:  if (i_memAck)   nxt = WT_TEX;
      WT_TEX:  if (i_memValid) nxt = use_clut ? RD_CLUT : fin_nxt;
      RD_CLUT: if (i_memAck)   nxt = WT_CLUT;
      WT_CLUT: if (i_memValid) nxt = fin_nxt;
      OUT:     if (i_texReady) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    req_d   = (nxt == RD_TEX) || (nxt == RD_CLUT);
    ready_d = (nxt == IDLE);
    valid_d = (nxt == OUT);
    adr_d   = o_memAdr;
    if (state == IDLE && nxt == RD_TEX)        adr_d = i_texAdrL;
    else if (nxt == RD_TEX && state != RD_TEX)   adr_d = adr_r;
    else if (nxt == RD_CLUT && state != RD_CLUT) adr_d = clut_adr;
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_memReq   <= 1'b0;
      o_memAdr   <= '0;
      o_reqReady <= 1'b1;
      o_texValid <= 1'b0;
    end else begin
      o_memReq   <= req_d;
      o_memAdr   <= adr_d;
      o_reqReady <= ready_d;
      o_texValid <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      adr_l    <= '0;
      adr_r    <= '0;
      sub_l    <= '0;
      sub_r    <= '0;
      fmt      <= '0;
      en_r     <= 1'b0;
      clut_x   <= '0;
      clut_y   <= '0;
      side     <= 1'b0;
      tex_word <= '0;
      o_texL   <= '0;
      o_texR   <= '0;
    end else begin
      if (state == IDLE && i_req) begin
        adr_l  <= i_texAdrL;
        adr_r  <= i_texAdrR;
        sub_l  <= i_subUL;
        sub_r  <= i_subUR;
        fmt    <= i_format;
        en_r   <= i_enR;
        clut_x <= i_clutX;
        clut_y <= i_clutY;
        side   <= 1'b0;
        o_texR <= '0;
      end
      if (state == WT_TEX && i_memValid) tex_word <= i_memData;
      if (go_r) side <= 1'b1;
      if (pix_done) begin
        if (side) o_texR <= i_memData;
        else      o_texL <= i_memData;
        // 16-bit R pixel sharing the L half-word is complete in the same cycle.
        if (go_r && shared && !use_clut) o_texR <= i_memData;
      end
    end
  end

endmodule

// File: tb/tb_texel_fetch.sv
// Bench for texel_fetch: behavioural VRAM responder with programmable delays and a reference
// model computing read sequence, colours and zero-wait latency from the format rules.
`timescale 1ns/1ps
module tb_texel_fetch;

  logic        clk = 1'b0;
  logic        i_nrst;
  logic        i_req;
  logic        o_reqReady;
  logic [18:0] i_texAdrL;
  logic [18:0] i_texAdrR;
  logic [1:0]  i_subUL;
  logic [1:0]  i_subUR;
  logic [1:0]  i_format;
  logic        i_enR;
  logic [5:0]  i_clutX;
  logic [8:0]  i_clutY;
  logic        o_memReq;
  logic [18:0] o_memAdr;
  logic        i_memAck;
  logic        i_memValid;
  logic [15:0] i_memData;
  logic        o_texValid;
  logic        i_texReady;
  logic [15:0] o_texL;
  logic [15:0] o_texR;

  int n_cmp = 0;
  int n_bad = 0;

  int          ack_dly = 0;
  int          dat_dly = 1;
  logic [15:0] seed = 16'h5a3c;
  logic [15:0] ovr [int];
  logic [18:0] rd_log [$];

  texel_fetch dut (
    .clk(clk), .i_nrst(i_nrst), .i_req(i_req), .o_reqReady(o_reqReady),
    .i_texAdrL(i_texAdrL), .i_texAdrR(i_texAdrR), .i_subUL(i_subUL), .i_subUR(i_subUR),
    .i_format(i_format), .i_enR(i_enR), .i_clutX(i_clutX), .i_clutY(i_clutY),
    .o_memReq(o_memReq), .o_memAdr(o_memAdr), .i_memAck(i_memAck), .i_memValid(i_memValid),
    .i_memData(i_memData), .o_texValid(o_texValid), .i_texReady(i_texReady),
    .o_texL(o_texL), .o_texR(o_texR)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memfn(input logic [18:0] a);
    logic [31:0] h;
    if (ovr.exists(int'(a))) return ovr[int'(a)];
    h = {13'd0, a} * 32'h9E3779B1;
    return h[31:16] ^ seed;
  endfunction

  function automatic logic [18:0] ref_clut(input logic [15:0] w, input logic [1:0] s,
                                           input logic [1:0] fm, input logic [5:0] cx,
                                           input logic [8:0] cy);
    int ix;
    int a;
    if (fm == 2'd0) ix = (int'(w) >> (int'(s) * 4)) & 15;
    else            ix = s[0] ? (int'(w) >> 8) : (int'(w) & 255);
    a = int'(cy) * 1024 + ((int'(cx) * 16 + ix) % 1024);
    return 19'(a);
  endfunction

  // VRAM responder: one outstanding read, ack after ack_dly cycles, data dat_dly cycles later.
  initial begin : responder
    int          phase;
    int          cnt;
    logic [18:0] cur;
    phase = 0; cnt = 0; cur = '0;
    i_memAck = 1'b0; i_memValid = 1'b0; i_memData = '0;
    forever begin
      @(negedge clk);
      i_memAck   = 1'b0;
      i_memValid = 1'b0;
      i_memData  = 16'($urandom);
      if (!i_nrst && phase == 1) phase = 0;
      case (phase)
        0: if (i_nrst && o_memReq) begin
             cur = o_memAdr;
             cnt = 0;
             if (ack_dly == 0) begin
               i_memAck = 1'b1; rd_log.push_back(cur); phase = 2;
             end else phase = 1;
           end
        1: begin
             n_cmp++;
             if (o_memReq !== 1'b1 || o_memAdr !== cur) begin
               n_bad++;
               $display("FAIL req_hold: memReq=%b adr=%h, required 1/%h", o_memReq, o_memAdr, cur);
             end
             cnt++;
             if (cnt >= ack_dly) begin
               i_memAck = 1'b1; rd_log.push_back(cur); phase = 2; cnt = 0;
             end
           end
        2: begin
             cnt++;
             if (i_nrst) begin
               n_cmp++;
               if (o_memReq !== 1'b0) begin
                 n_bad++;
                 $display("FAIL dup_req: memReq=%b adr=%h while a read is outstanding, required 0",
                          o_memReq, o_memAdr);
               end
             end
             if (cnt >= dat_dly) begin
               i_memValid = 1'b1; i_memData = memfn(cur); phase = 0;
             end
           end
        default: phase = 0;
      endcase
    end
  end

  task automatic scramble_inputs;
    i_texAdrL = 19'($urandom); i_texAdrR = 19'($urandom);
    i_subUL = 2'($urandom); i_subUR = 2'($urandom); i_format = 2'($urandom);
    i_enR = 1'($urandom); i_clutX = 6'($urandom); i_clutY = 9'($urandom);
  endtask

  task automatic run_txn(input logic [18:0] al, input logic [18:0] ar, input logic [1:0] sl,
                         input logic [1:0] sr, input logic [1:0] fm, input logic er,
                         input logic [5:0] cx, input logic [8:0] cy, input int hold,
                         input logic junk, input string name);
    logic [18:0] exp_rd [$];
    logic [18:0] a;
    logic [15:0] w;
    logic [15:0] el;
    logic [15:0] erc;
    logic        clut;
    logic        got;
    int          idx;
    clut = (fm < 2'd2);
    exp_rd.push_back(al);
    w = memfn(al);
    if (clut) begin a = ref_clut(w, sl, fm, cx, cy); exp_rd.push_back(a); el = memfn(a); end
    else el = w;
    if (er) begin
      if (ar != al) begin exp_rd.push_back(ar); w = memfn(ar); end
      if (clut) begin a = ref_clut(w, sr, fm, cx, cy); exp_rd.push_back(a); erc = memfn(a); end
      else erc = w;
    end else erc = 16'd0;

    rd_log.delete();
    @(negedge clk);
    i_req = 1'b1; i_texAdrL = al; i_texAdrR = ar; i_subUL = sl; i_subUR = sr;
    i_format = fm; i_enR = er; i_clutX = cx; i_clutY = cy;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (o_reqReady === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s accept_timeout: reqReady=%b, required 1", name, o_reqReady);
      i_req = 1'b0;
      return;
    end
    @(posedge clk);
    idx = 0;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      idx++;
      i_req = junk;
      scramble_inputs();
      if (o_texValid === 1'b1) got = 1'b1;
      else begin
        n_cmp++;
        if (o_reqReady !== 1'b0) begin
          n_bad++;
          $display("FAIL %s busy_ready: reqReady=%b at cycle %0d, required 0", name, o_reqReady, idx);
        end
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s valid_timeout: texValid=%b, required 1", name, o_texValid);
      i_req = 1'b0;
      return;
    end
    if (ack_dly == 0 && dat_dly == 1) begin
      n_cmp++;
      if (idx != 2 * exp_rd.size() + 1) begin
        n_bad++;
        $display("FAIL %s latency: %0d cycles, required %0d", name, idx, 2 * exp_rd.size() + 1);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      n_cmp++;
      if (o_texValid !== 1'b1 || o_texL !== el || o_texR !== erc || o_reqReady !== 1'b0) begin
        n_bad++;
        $display("FAIL %s result: valid=%b L=%h R=%h rdy=%b, required 1 %h %h 0",
                 name, o_texValid, o_texL, o_texR, o_reqReady, el, erc);
      end
    end
    i_texReady = 1'b1;
    i_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_texReady = 1'b0;
    n_cmp++;
    if (o_texValid !== 1'b0 || o_reqReady !== 1'b1) begin
      n_bad++;
      $display("FAIL %s release: valid=%b rdy=%b, required 0 1", name, o_texValid, o_reqReady);
    end
    n_cmp++;
    if (rd_log.size() != exp_rd.size()) begin
      n_bad++;
      $display("FAIL %s read_count: %0d reads, required %0d", name, rd_log.size(), exp_rd.size());
    end
    for (int k = 0; k < exp_rd.size() && k < rd_log.size(); k++) begin
      n_cmp++;
      if (rd_log[k] !== exp_rd[k]) begin
        n_bad++;
        $display("FAIL %s read_adr[%0d]: %h, required %h", name, k, rd_log[k], exp_rd[k]);
      end
    end
  endtask

  task automatic test_reset;
    i_nrst = 1'b0; i_req = 1'b0; i_texReady = 1'b0;
    i_texAdrL = '0; i_texAdrR = '0; i_subUL = '0; i_subUR = '0; i_format = '0;
    i_enR = 1'b0; i_clutX = '0; i_clutY = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_reqReady !== 1'b1 || o_memReq !== 1'b0 || o_memAdr !== 19'd0 ||
        o_texValid !== 1'b0 || o_texL !== 16'd0 || o_texR !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b req=%b adr=%h valid=%b L=%h R=%h, required 1 0 0 0 0 0",
               o_reqReady, o_memReq, o_memAdr, o_texValid, o_texL, o_texR);
    end
    i_nrst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (o_reqReady !== 1'b1 || o_memReq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: rdy=%b req=%b, required 1 0", o_reqReady, o_memReq);
    end
  endtask

  task automatic test_16bit;
    ovr[int'(19'h00040)] = 16'h1234;
    ovr[int'(19'h00041)] = 16'h5678;
    run_txn(19'h00040, 19'h00041, 2'd0, 2'd0, 2'd2, 1'b1, 6'd0, 9'd0, 0, 1'b0, "tex16");
  endtask

  task automatic test_clut_shared;
    ovr[int'(19'h12345)] = 16'hA5C3;
    run_txn(19'h12345, 19'h12345, 2'd1, 2'd3, 2'd0, 1'b1, 6'd2, 9'd480, 0, 1'b0, "clut4_shared");
    n_cmp++;
    if (rd_log.size() != 3 || rd_log[1] !== {9'd480, 10'd44} || rd_log[2] !== {9'd480, 10'd42}) begin
      n_bad++;
      $display("FAIL clut4_shared_adr: %0d reads, required CLUT reads %h %h",
               rd_log.size(), {9'd480, 10'd44}, {9'd480, 10'd42});
    end
  endtask

  task automatic test_clut_wrap;
    logic [8:0] cy;
    cy = 9'($urandom);
    ovr[int'(19'h0abcd)] = 16'hF012;
    run_txn(19'h0abcd, 19'h0abce, 2'd1, 2'd0, 2'd1, 1'b0, 6'd63, cy, 1, 1'b1, "clut8_wrap");
    n_cmp++;
    if (rd_log.size() != 2 || rd_log[1] !== {cy, 10'd224}) begin
      n_bad++;
      $display("FAIL clut8_wrap_adr: %0d reads, required 2 with CLUT adr %h", rd_log.size(),
               {cy, 10'd224});
    end
  endtask

  task automatic test_enr_off;
    run_txn(19'($urandom), 19'($urandom), 2'($urandom), 2'($urandom), 2'd0, 1'b0,
            6'($urandom), 9'($urandom), 3, 1'b1, "enr_off");
  endtask

  task automatic test_stall;
    ack_dly = 4; dat_dly = 6;
    run_txn(19'h01000, 19'h01001, 2'd2, 2'd1, 2'd0, 1'b1, 6'd5, 9'd7, 1, 1'b0, "stall");
    ack_dly = 0; dat_dly = 1;
  endtask

  task automatic test_reset_midop;
    logic seen_valid;
    logic seen_req;
    ack_dly = 0; dat_dly = 12;
    rd_log.delete();
    @(negedge clk);
    i_req = 1'b1; i_texAdrL = 19'h00100; i_texAdrR = 19'h00200; i_subUL = 2'd1; i_subUR = 2'd2;
    i_format = 2'd0; i_enR = 1'b1; i_clutX = 6'd9; i_clutY = 9'd3;
    @(posedge clk);
    @(negedge clk);
    i_req = 1'b0;
    for (int k = 0; k < 300 && rd_log.size() < 4; k++) @(negedge clk);
    n_cmp++;
    if (rd_log.size() < 4) begin
      n_bad++;
      $display("FAIL midop_progress: %0d reads, required 4", rd_log.size());
    end
    repeat (2) @(negedge clk);
    i_nrst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_reqReady !== 1'b1 || o_memReq !== 1'b0 || o_memAdr !== 19'd0 ||
        o_texValid !== 1'b0 || o_texL !== 16'd0 || o_texR !== 16'd0) begin
      n_bad++;
      $display("FAIL midop_reset: rdy=%b req=%b adr=%h valid=%b L=%h R=%h, required 1 0 0 0 0 0",
               o_reqReady, o_memReq, o_memAdr, o_texValid, o_texL, o_texR);
    end
    i_nrst = 1'b1;
    seen_valid = 1'b0;
    seen_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_texValid !== 1'b0) seen_valid = 1'b1;
      if (o_memReq !== 1'b0) seen_req = 1'b1;
    end
    n_cmp++;
    if (seen_valid || seen_req || o_reqReady !== 1'b1) begin
      n_bad++;
      $display("FAIL midop_late_data: valid_seen=%b req_seen=%b rdy=%b, required 0 0 1",
               seen_valid, seen_req, o_reqReady);
    end
    dat_dly = 1;
    run_txn(19'h00300, 19'h00305, 2'd3, 2'd0, 2'd0, 1'b1, 6'd1, 9'd2, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 40; n++) begin
      logic [18:0] al;
      logic [18:0] ar;
      al = 19'($urandom);
      ar = ($urandom_range(0, 3) == 0) ? al : 19'($urandom);
      ack_dly = (n < 10) ? 0 : int'($urandom_range(0, 3));
      dat_dly = (n < 10) ? 1 : int'($urandom_range(1, 4));
      run_txn(al, ar, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
              6'($urandom), 9'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "random");
    end
    ack_dly = 0; dat_dly = 1;
  endtask

  initial begin
    i_nrst = 1'b0;
    test_reset();
    test_16bit();
    test_clut_shared();
    test_clut_wrap();
    test_enr_off();
    test_stall();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
